// File: rtl/fir_mac_arbiter_if.sv
// Bus between the FIR requesters and the shared complex multiplier arbiter.
// The FIR side drives requests and operands (master); the arbiter drives
// grants and tagged products back (slave).
interface fir_mac_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            op_valid;
  logic [NUM_REQ-1:0]            op_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] a_re;
  logic [NUM_REQ*DATA_WIDTH-1:0] a_im;
  logic [NUM_REQ*DATA_WIDTH-1:0] b_re;
  logic [NUM_REQ*DATA_WIDTH-1:0] b_im;
  logic [NUM_REQ-1:0]            grant;
  logic                          prod_valid;
  logic [DATA_WIDTH-1:0]         prod_re;
  logic [DATA_WIDTH-1:0]         prod_im;
  logic [ID_WIDTH-1:0]           prod_id;
  logic                          prod_last;
  logic                          overrun;

  modport master (
    output req, op_valid, op_last, a_re, a_im, b_re, b_im,
    input  grant, prod_valid, prod_re, prod_im, prod_id, prod_last, overrun
  );

  modport slave (
    input  req, op_valid, op_last, a_re, a_im, b_re, b_im,
    output grant, prod_valid, prod_re, prod_im, prod_id, prod_last, overrun
  );
endinterface

// File: rtl/fir_mac_arbiter.sv
// Round-robin arbiter sharing one pipelined complex Q.10 multiplier between
// NUM_REQ FIR requesters. A granted requester streams a burst of operand
// pairs; products come back two cycles later tagged with the owner index.
module fir_mac_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input logic             clock,
  input logic             reset,
  fir_mac_arbiter_if.slave bus
);
  localparam int FRAC  = 10;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = ($clog2(MAX_BURST + 1) > 7) ? $clog2(MAX_BURST + 1) : 7;

  typedef enum logic { IDLE, BUSY } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] owner;      // current owner in BUSY, previous owner in IDLE
  logic [CNT_W-1:0]    burst_cnt;
  logic [NUM_REQ-1:0]  grant_q;
  logic                overrun_q;

  logic                         own_req, own_valid, own_last;
  logic signed [DATA_WIDTH-1:0] sel_a_re, sel_a_im, sel_b_re, sel_b_im;

  // Route the owner's request, handshake and operands to the multiplier.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path that leaves one unassigned infers a latch.
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    sel_a_re  = '0;
    sel_a_im  = '0;
    sel_b_re  = '0;
    sel_b_im  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == ID_WIDTH'(k)) begin
        own_req   = bus.req[k];
        own_valid = bus.op_valid[k];
        own_last  = bus.op_last[k];
        sel_a_re  = bus.a_re[k*DATA_WIDTH +: DATA_WIDTH];
        sel_a_im  = bus.a_im[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b_re  = bus.b_re[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b_im  = bus.b_im[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Requests rotated so bit j is requester (owner+1+j) mod NUM_REQ; the
  // owner lands in the top bit and therefore only wins when it is alone.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  assign req_dbl = {bus.req, bus.req} >> ({1'b0, owner} + 1'b1);
  assign req_rot = req_dbl[NUM_REQ-1:0];

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [NUM_REQ-1:0]  pick_onehot;
  int                  cand;

  // Pick the first pending request after the owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = owner;
    cand       = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        cand = int'(owner) + 1 + j;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        pick_found = 1'b1;
        pick_id    = ID_WIDTH'(cand);
      end
    end
  end
  assign pick_onehot = NUM_REQ'(1) << pick_id;

  logic accept, acc_last, force_rel, abandon, burst_end;
  assign accept    = (state == BUSY) && own_valid;
  assign acc_last  = accept && own_last;
  assign force_rel = accept && (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign abandon   = (state == BUSY) && !own_req && !own_valid;
  assign burst_end = acc_last || force_rel || abandon;

  // Grant FSM: load a new owner from IDLE or hand over at burst end with no gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt <= '0;
      grant_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: state uses <= so every register samples pre-edge values; = would make results depend on block evaluation order.
      if (force_rel) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BUSY;
            owner     <= pick_id;
            grant_q   <= pick_onehot;
            burst_cnt <= '0;
          end
        end
        BUSY: begin
          if (burst_end) begin
            if (pick_found) begin
              owner     <= pick_id;
              grant_q   <= pick_onehot;
              burst_cnt <= '0;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  logic signed [PW-1:0] mul_rr, mul_ii, mul_ri, mul_ir;
  assign mul_rr = PW'(sel_a_re) * PW'(sel_b_re);
  assign mul_ii = PW'(sel_a_im) * PW'(sel_b_im);
  assign mul_ri = PW'(sel_a_re) * PW'(sel_b_im);
  assign mul_ir = PW'(sel_a_im) * PW'(sel_b_re);

  logic                 s1_valid, s1_last;
  logic [ID_WIDTH-1:0]  s1_id;
  logic signed [PW-1:0] s1_rr, s1_ii, s1_ri, s1_ir;

  // Stage 1: register the four full-width partial products with their tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset as well because the product outputs have defined reset values.
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_id    <= '0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_ri    <= '0;
      s1_ir    <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= acc_last || force_rel;
      s1_id    <= owner;
      s1_rr    <= mul_rr;
      s1_ii    <= mul_ii;
      s1_ri    <= mul_ri;
      s1_ir    <= mul_ir;
    end
  end

  // Each partial is rescaled to Q.10 before summing; the sum wraps.
  logic signed [PW-1:0] sum_re, sum_im;
  assign sum_re = (s1_rr >>> FRAC) - (s1_ii >>> FRAC);
  assign sum_im = (s1_ri >>> FRAC) + (s1_ir >>> FRAC);

  logic                  s2_valid, s2_last;
  logic [ID_WIDTH-1:0]   s2_id;
  logic [DATA_WIDTH-1:0] s2_re, s2_im;

  // Stage 2: register the wrapped complex product as the block output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_id    <= '0;
      s2_re    <= '0;
      s2_im    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_id    <= s1_id;
      s2_re    <= sum_re[DATA_WIDTH-1:0];
      s2_im    <= sum_im[DATA_WIDTH-1:0];
    end
  end

  assign bus.grant      = grant_q;
  assign bus.overrun    = overrun_q;
  assign bus.prod_valid = s2_valid;
  assign bus.prod_last  = s2_last;
  assign bus.prod_id    = s2_id;
  assign bus.prod_re    = s2_re;
  assign bus.prod_im    = s2_im;
endmodule

// File: doc/fir_mac_arbiter.md
# fir_mac_arbiter

Round-robin arbiter that shares one pipelined complex fixed-point (Q.10) multiplier between up to NUM_REQ FIR filter instances in the FM demod chain. Each filter requests a burst of tap products (one per cycle). It holds the grant until it flags the last product, then releases it. Products return tagged with the owner's index after a fixed 2-cycle latency. This lets several decimating/complex FIR stages run their RUN phases on one set of DSP multipliers instead of four multipliers each.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: operand/product width, two's complement, 10 fractional bits.
- MAX_BURST, 64: maximum operands accepted per grant before forced release.
- ID_WIDTH, $clog2(NUM_REQ): width of the owner tag.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  NUM_REQ  per-requester burst request, level.
- op_valid  in  NUM_REQ  operand pair present this cycle.
- op_last  in  NUM_REQ  qualifies op_valid: final operand of burst.
- a_re, a_im  in  NUM_REQ*DATA_WIDTH  packed coefficient operands, requester k at slice k.
- b_re, b_im  in  NUM_REQ*DATA_WIDTH  packed sample operands.
- grant  out  NUM_REQ  one-hot registered grant (all-zero when idle).
- prod_valid  out  1  product output valid.
- prod_re, prod_im  out  DATA_WIDTH  complex product.
- prod_id  out  ID_WIDTH  owner index of the product.
- prod_last  out  1  product corresponds to the burst's op_last.
- overrun  out  1  sticky: a burst was force-released at MAX_BURST.

## Operation
- States: IDLE (grant=0), BUSY (grant one-hot, owner register held).
- IDLE: if any req, the next owner is the first set req bit scanning from (last_owner+1) mod NUM_REQ upward with wrap. That owner is granted on the next edge. last_owner resets to NUM_REQ-1, so requester 0 wins first.
- BUSY: an operand is accepted in a cycle where grant[k] && op_valid[k]. op_valid from non-granted requesters is ignored; those requesters must hold their operands.
- Burst end occurs on any of the following:
  - accepted op_last[k];
  - req[k] deasserted with no op_valid that cycle, which is an abandon: no prod_last is produced;
  - burst count reaching MAX_BURST. On forced release, overrun is set and that product gets prod_last=1.
- Handover: in the burst-end cycle, the next owner is computed from req, excluding the current owner. The current owner is included only if it is the sole requester. The new grant is loaded on the same edge, giving zero idle cycles. If no req is pending, go to IDLE.
- Burst counter: clears on grant; increments per accepted operand; 7 bits minimum.
- Arithmetic, with each partial computed as (signed(x)*signed(y)) >> 10 arithmetic, keeping the low DATA_WIDTH bits:
  - prod_re = p(a_re,b_re) − p(a_im,b_im);
  - prod_im = p(a_re,b_im) + p(a_im,b_re);
  - wraps on overflow, no saturation.
- overrun clears only on reset.

## Timing
- Reset values: grant=0, prod_valid=0, prod_re=prod_im=0, prod_id=0, prod_last=0, overrun=0, state IDLE, pipeline valids cleared.
- Grant latency: req rising in IDLE at cycle t gives grant at t+1. Earliest operand acceptance is t+1.
- Pipeline: operand accepted at edge t. Stage 1 registers the four 64-bit products plus id/last/valid. Stage 2 registers the shifted sums. Outputs appear at t+2, one product per cycle sustained, fully pipelined with no backpressure.
- Back-to-back bursts from different owners: products stay in acceptance order; prod_id changes cycle-exactly.
- Reset mid-burst: in-flight products are discarded, and prod_valid is low from reset assertion onward.
- grant changes only on clock edges; it never glitches combinationally.

## Test plan
- Single owner: req[0]=1, 20 operands with a_re=0x400 (1.0), a_im=0, b_re=k, b_im=−k, last on the 20th. Expected: grant=0001 at t+1; products (k,−k), prod_id=0, prod_last on the 20th, 2 cycles after each accept.
- Complex math: a=(0x400,0x400), b=(0x800,0xFFFFFC00). Expected: prod_re=0xC00, prod_im=0x400.
- Round-robin: req=1111 held, each burst 3 operands. Expected: grant order 0,1,2,3,0, no idle cycles between bursts.
- Abandon: owner 2 drops req after 2 operands without last. Expected: grant moves to the next requester, 2 products out with prod_last=0, overrun stays 0.
- Forced release: MAX_BURST=64, owner streams 70 operands with no last. Expected: 64 accepted, 64th has prod_last=1, overrun=1 sticky, grant moves on or goes idle.
- Reset mid-burst at the 5th operand. Expected: all outputs zero next cycle, no stale prod_valid; after release, requester 0 is granted first.
